// File: rtl/if_id_flush_reg_if.sv
// ---------------------------------------------------------------------------
// if_id_flush_reg_if
//
// Bundles the IF-side inputs, the hazard requests and the ID-side outputs of
// the IF/ID pipeline register.
//
// Parameters:
//   DATA_W  width of the PC, PC+4 and instruction fields
//   CNT_W   width of the flush and bubble activity counters
//
// Signals:
//   flush, stall                 hazard requests to the IF/ID register
//   if_valid, if_pc, if_pc4,
//   if_inst                      fetch-stage slot contents
//   id_valid, id_squashed,
//   id_pc, id_pc4, id_inst       registered decode-stage slot contents
//   flush_cnt, bubble_cnt        saturating activity counters (debug path)
//
// Modports:
//   master  drives the fetch/hazard side and observes the ID side
//   slave   the pipeline register itself
// ---------------------------------------------------------------------------
interface if_id_flush_reg_if #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
);
  logic              flush;
  logic              stall;
  logic              if_valid;
  logic [DATA_W-1:0] if_pc;
  logic [DATA_W-1:0] if_pc4;
  logic [DATA_W-1:0] if_inst;

  logic              id_valid;
  logic              id_squashed;
  logic [DATA_W-1:0] id_pc;
  logic [DATA_W-1:0] id_pc4;
  logic [DATA_W-1:0] id_inst;
  logic [CNT_W-1:0]  flush_cnt;
  logic [CNT_W-1:0]  bubble_cnt;

  modport master (
    output flush, stall, if_valid, if_pc, if_pc4, if_inst,
    input  id_valid, id_squashed, id_pc, id_pc4, id_inst, flush_cnt, bubble_cnt
  );

  modport slave (
    input  flush, stall, if_valid, if_pc, if_pc4, if_inst,
    output id_valid, id_squashed, id_pc, id_pc4, id_inst, flush_cnt, bubble_cnt
  );
endinterface

// File: rtl/if_id_flush_reg.sv
// ---------------------------------------------------------------------------
// if_id_flush_reg
//
// IF/ID pipeline register with flush (squash) and stall (hold) handling.
// Squashed or invalid slots are replaced by a NOP bubble. A three-state FSM
// tracks whether the slot was loaded normally (RUN), frozen (HOLD) or
// squashed (SQUASH). Two saturating counters report flush requests and
// bubble cycles to the debug path.
//
// Ports:
//   clk    rising-edge clock
//   rst_n  synchronous, active-low reset
//   bus    if_id_flush_reg_if.slave: flush, stall, if_* inputs;
//          id_* outputs, flush_cnt, bubble_cnt
//
// All outputs come straight from flops; there is no input-to-output
// combinational path.
// ---------------------------------------------------------------------------
module if_id_flush_reg #(
  parameter int                DATA_W   = 32,
  parameter logic [DATA_W-1:0] NOP_INST = 32'h0000_0013,
  parameter int                CNT_W    = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  if_id_flush_reg_if.slave   bus
);

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_HOLD   = 2'd1,
    ST_SQUASH = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t            state_q,       state_d;
  logic              id_valid_q,    id_valid_d;
  logic              id_squashed_q, id_squashed_d;
  logic [DATA_W-1:0] id_pc_q,       id_pc_d;
  logic [DATA_W-1:0] id_pc4_q,      id_pc4_d;
  logic [DATA_W-1:0] id_inst_q,     id_inst_d;
  logic [CNT_W-1:0]  flush_cnt_q,   flush_cnt_d;
  logic [CNT_W-1:0]  bubble_cnt_q,  bubble_cnt_d;

  // Slot update: flush beats stall so a wrong-path instruction can never
  // survive a load-use stall; stall beats a normal load.
  always_comb begin
    state_d       = state_q;
    id_valid_d    = id_valid_q;
    id_squashed_d = id_squashed_q;
    id_pc_d       = id_pc_q;
    id_pc4_d      = id_pc4_q;
    id_inst_d     = id_inst_q;

    if (bus.flush) begin
      state_d       = ST_SQUASH;
      id_valid_d    = 1'b0;
      id_squashed_d = 1'b1;
      id_pc_d       = '0;
      id_pc4_d      = '0;
      id_inst_d     = NOP_INST;
    end else if (bus.stall) begin
      // Contents (including a squashed bubble's flag) are simply retained.
      state_d = ST_HOLD;
    end else begin
      state_d       = ST_RUN;
      id_valid_d    = bus.if_valid;
      id_squashed_d = 1'b0;
      id_pc_d       = bus.if_pc;
      id_pc4_d      = bus.if_pc4;
      id_inst_d     = bus.if_valid ? bus.if_inst : NOP_INST;
    end
  end

  // Saturating activity counters. bubble_cnt looks at the slot currently
  // presented, so a held bubble is counted every cycle it sits in ID.
  always_comb begin
    flush_cnt_d  = flush_cnt_q;
    bubble_cnt_d = bubble_cnt_q;
    if (bus.flush && (flush_cnt_q != CNT_MAX)) begin
      flush_cnt_d = flush_cnt_q + CNT_W'(1);
    end
    if (!id_valid_q && (bubble_cnt_q != CNT_MAX)) begin
      bubble_cnt_d = bubble_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= ST_RUN;
      id_valid_q    <= 1'b0;
      id_squashed_q <= 1'b0;
      id_pc_q       <= '0;
      id_pc4_q      <= '0;
      id_inst_q     <= NOP_INST;
      flush_cnt_q   <= '0;
      bubble_cnt_q  <= '0;
    end else begin
      state_q       <= state_d;
      id_valid_q    <= id_valid_d;
      id_squashed_q <= id_squashed_d;
      id_pc_q       <= id_pc_d;
      id_pc4_q      <= id_pc4_d;
      id_inst_q     <= id_inst_d;
      flush_cnt_q   <= flush_cnt_d;
      bubble_cnt_q  <= bubble_cnt_d;
    end
  end

  assign bus.id_valid    = id_valid_q;
  assign bus.id_squashed = id_squashed_q;
  assign bus.id_pc       = id_pc_q;
  assign bus.id_pc4      = id_pc4_q;
  assign bus.id_inst     = id_inst_q;
  assign bus.flush_cnt   = flush_cnt_q;
  assign bus.bubble_cnt  = bubble_cnt_q;

endmodule

// File: tb/tb_if_id_flush_reg.sv
// ---------------------------------------------------------------------------
// tb_if_id_flush_reg
//
// Directed stimulus for if_id_flush_reg with 4-bit counters so saturation is
// reachable. Each driven cycle pushes its hand-computed expected ID-stage
// contents into a queue; a monitor pops one entry after every clock edge and
// compares it with the registered outputs.
// ---------------------------------------------------------------------------
module tb_if_id_flush_reg;

  localparam int          DATA_W = 32;
  localparam int          CNT_W  = 4;
  localparam logic [31:0] NOP    = 32'h0000_0013;
  localparam logic [1:0]  R      = 2'd0;  // RUN
  localparam logic [1:0]  H      = 2'd1;  // HOLD
  localparam logic [1:0]  S      = 2'd2;  // SQUASH

  logic clk;
  logic rst_n;

  if_id_flush_reg_if #(.DATA_W(DATA_W), .CNT_W(CNT_W)) bus ();

  if_id_flush_reg #(
    .DATA_W  (DATA_W),
    .NOP_INST(NOP),
    .CNT_W   (CNT_W)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int          id;
    logic        v;
    logic        sq;
    logic [31:0] pc;
    logic [31:0] pc4;
    logic [31:0] inst;
    logic [1:0]  st;
    logic [3:0]  fc;
    logic [3:0]  bc;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   txn    = 0;

  task automatic chk(input string name, input int id, input logic [31:0] act,
                     input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL txn %0d %s: got 0x%08h expected 0x%08h", id, name, act, req);
    end
  endtask

  // Monitor: one expected entry is consumed per clock edge.
  always @(posedge clk) begin
    #1;
    if (exp_q.size() > 0) begin
      exp_t e;
      logic [1:0] st_now;
      e      = exp_q.pop_front();
      st_now = dut.state_q;
      chk("id_valid",    e.id, {31'b0, bus.id_valid},    {31'b0, e.v});
      chk("id_squashed", e.id, {31'b0, bus.id_squashed}, {31'b0, e.sq});
      chk("id_pc",       e.id, bus.id_pc,   e.pc);
      chk("id_pc4",      e.id, bus.id_pc4,  e.pc4);
      chk("id_inst",     e.id, bus.id_inst, e.inst);
      chk("state",       e.id, {30'b0, st_now},         {30'b0, e.st});
      chk("flush_cnt",   e.id, {28'b0, bus.flush_cnt},  {28'b0, e.fc});
      chk("bubble_cnt",  e.id, {28'b0, bus.bubble_cnt}, {28'b0, e.bc});
      $display("txn %0d: v=%0b sq=%0b pc=0x%08h inst=0x%08h fc=%0d bc=%0d",
               e.id, bus.id_valid, bus.id_squashed, bus.id_pc, bus.id_inst,
               bus.flush_cnt, bus.bubble_cnt);
    end
  end

  // One cycle of stimulus plus its expected outcome after the next edge.
  // rst is active-high here and drives rst_n low. Expected PC+4 is 0 for a
  // reset or squashed slot, otherwise expected PC + 4 (bench drives pc4=pc+4).
  task automatic drive(input logic rst, input logic fl, input logic st,
                       input logic v, input logic [31:0] pc, input logic [31:0] inst,
                       input logic ev, input logic esq, input logic [31:0] epc,
                       input logic [31:0] einst, input logic [1:0] est,
                       input int efc, input int ebc);
    exp_t e;
    @(negedge clk);
    rst_n        = ~rst;
    bus.flush    = fl;
    bus.stall    = st;
    bus.if_valid = v;
    bus.if_pc    = pc;
    bus.if_pc4   = pc + 32'd4;
    bus.if_inst  = inst;
    txn++;
    e.id   = txn;
    e.v    = ev;
    e.sq   = esq;
    e.pc   = epc;
    e.pc4  = (rst || esq) ? 32'd0 : epc + 32'd4;
    e.inst = einst;
    e.st   = est;
    e.fc   = 4'(efc);
    e.bc   = 4'(ebc);
    exp_q.push_back(e);
  endtask

  initial begin
    rst_n        = 1'b0;
    bus.flush    = 1'b0;
    bus.stall    = 1'b0;
    bus.if_valid = 1'b0;
    bus.if_pc    = '0;
    bus.if_pc4   = '0;
    bus.if_inst  = '0;

    // Reset with flush and stall asserted: reset wins.
    drive(1, 1, 1, 1, 32'h100, 32'hdead_beef, 0, 0, 32'h0,  NOP, R, 0, 0);
    drive(1, 1, 1, 1, 32'h104, 32'hdead_beef, 0, 0, 32'h0,  NOP, R, 0, 0);

    // Normal flow: first load counts the reset bubble, then bubble_cnt holds.
    drive(0, 0, 0, 1, 32'h00, 32'h0050_0093, 1, 0, 32'h00, 32'h0050_0093, R, 0, 1);
    drive(0, 0, 0, 1, 32'h04, 32'h00a0_0113, 1, 0, 32'h04, 32'h00a0_0113, R, 0, 1);
    drive(0, 0, 0, 1, 32'h08, 32'h00f0_0193, 1, 0, 32'h08, 32'h00f0_0193, R, 0, 1);

    // Single-cycle flush while pc=0x10 is presented, then normal load.
    drive(0, 1, 0, 1, 32'h10, 32'h0010_8093, 0, 1, 32'h00, NOP,           S, 1, 1);
    drive(0, 0, 0, 1, 32'h14, 32'h0020_8093, 1, 0, 32'h14, 32'h0020_8093, R, 1, 2);

    // Stall for 3 cycles after pc=0x20 is loaded, release loads pc=0x30.
    drive(0, 0, 0, 1, 32'h20, 32'h0030_8093, 1, 0, 32'h20, 32'h0030_8093, R, 1, 2);
    drive(0, 0, 1, 1, 32'h24, 32'h0040_8093, 1, 0, 32'h20, 32'h0030_8093, H, 1, 2);
    drive(0, 0, 1, 1, 32'h28, 32'h0040_8093, 1, 0, 32'h20, 32'h0030_8093, H, 1, 2);
    drive(0, 0, 1, 1, 32'h2c, 32'h0040_8093, 1, 0, 32'h20, 32'h0030_8093, H, 1, 2);
    drive(0, 0, 0, 1, 32'h30, 32'h0050_8093, 1, 0, 32'h30, 32'h0050_8093, R, 1, 2);

    // Invalid fetch loads a NOP with its PC, not flagged as squashed.
    drive(0, 0, 0, 0, 32'h34, 32'hdead_beef, 0, 0, 32'h34, NOP,           R, 1, 2);
    drive(0, 0, 0, 1, 32'h38, 32'h0060_8093, 1, 0, 32'h38, 32'h0060_8093, R, 1, 3);

    // Flush and stall together: squashed, then bubble held for 2 stalls.
    drive(0, 1, 1, 1, 32'h3c, 32'h00a0_8093, 0, 1, 32'h00, NOP,           S, 2, 3);
    drive(0, 0, 1, 1, 32'h40, 32'h00b0_8093, 0, 1, 32'h00, NOP,           H, 2, 4);
    drive(0, 0, 1, 1, 32'h40, 32'h00b0_8093, 0, 1, 32'h00, NOP,           H, 2, 5);
    drive(0, 0, 0, 1, 32'h44, 32'h0070_8093, 1, 0, 32'h44, 32'h0070_8093, R, 2, 6);

    // HOLD -> SQUASH, then a 2-cycle flush gives 2 consecutive bubbles.
    drive(0, 0, 1, 1, 32'h48, 32'h00c0_8093, 1, 0, 32'h44, 32'h0070_8093, H, 2, 6);
    drive(0, 1, 0, 1, 32'h48, 32'h00c0_8093, 0, 1, 32'h00, NOP,           S, 3, 6);
    drive(0, 1, 0, 1, 32'h48, 32'h00c0_8093, 0, 1, 32'h00, NOP,           S, 4, 7);
    drive(0, 0, 0, 1, 32'h4c, 32'h0080_8093, 1, 0, 32'h4c, 32'h0080_8093, R, 4, 8);

    // Reset asserted mid-squash returns everything to reset values.
    drive(0, 1, 0, 1, 32'h50, 32'h00d0_8093, 0, 1, 32'h00, NOP,           S, 5, 8);
    drive(1, 1, 1, 1, 32'h54, 32'h00d0_8093, 0, 0, 32'h00, NOP,           R, 0, 0);

    // Saturation: 20 flush cycles, both counters stop at 15.
    for (int k = 1; k <= 20; k++) begin
      drive(0, 1, 0, 1, 32'h60, 32'h00e0_8093, 0, 1, 32'h00, NOP, S,
            (k > 15) ? 15 : k, (k > 15) ? 15 : k);
    end
    drive(0, 0, 0, 1, 32'h64, 32'h00f0_8093, 1, 0, 32'h64, 32'h00f0_8093, R, 15, 15);

    @(negedge clk);
    @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d entries left expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got no completion expected finish before 100000 time units");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/if_id_flush_reg.md
# if_id_flush_reg

IF/ID pipeline register that consumes the `flush` request from the hazard detection unit and the load-use `stall` request. It captures fetch-stage PC, PC+4 and instruction, and replaces squashed or invalid instructions with a NOP bubble. A small state machine tracks whether the ID contents are live, held or squashed. Saturating counters report flush and bubble activity to the debug path.

## Interface
- `DATA_W`, 32, width of PC, PC+4 and instruction fields
- `NOP_INST`, 32'h0000_0013, bubble instruction (addi x0,x0,0)
- `CNT_W`, 16, width of performance counters
- `clk`  in  1  rising-edge clock
- `rst_n`  in  1  reset, synchronous, active-low
- `flush`  in  1  squash request (branch/jump taken), combinational from hazard unit
- `stall`  in  1  hold request (load-use hazard)
- `if_valid`  in  1  fetch stage presents a real instruction
- `if_pc`  in  DATA_W  fetch PC
- `if_pc4`  in  DATA_W  fetch PC+4
- `if_inst`  in  DATA_W  fetched instruction
- `id_valid`  out  1  ID contents are a real instruction
- `id_squashed`  out  1  ID contents are a flush bubble
- `id_pc`  out  DATA_W  registered PC
- `id_pc4`  out  DATA_W  registered PC+4
- `id_inst`  out  DATA_W  registered instruction, or NOP_INST when not valid
- `flush_cnt`  out  CNT_W  cycles in which flush was sampled high, saturating
- `bubble_cnt`  out  CNT_W  cycles in which id_valid was low, saturating

## Operation
- States: RUN (live or empty slot loaded normally), HOLD (contents frozen by stall), SQUASH (slot holds a flush bubble).
- Priority at each edge: reset > flush > stall > load.
- flush=1: id_valid←0, id_squashed←1, id_inst←NOP_INST, id_pc/id_pc4←0. Next state SQUASH, regardless of the current state or stall.
- stall=1 and flush=0: all data outputs hold, and next state is HOLD. If the held contents are a bubble, id_squashed stays 1.
- stall=0 and flush=0: load. id_valid←if_valid, id_squashed←0, id_inst←if_valid ? if_inst : NOP_INST, id_pc←if_pc, id_pc4←if_pc4. Next state RUN.
- Transitions:
  - RUN→SQUASH on flush; RUN→HOLD on stall; otherwise RUN.
  - HOLD→SQUASH on flush; HOLD→HOLD on stall; otherwise HOLD→RUN.
  - SQUASH→SQUASH on flush; SQUASH→HOLD on stall (bubble retained); otherwise SQUASH→RUN.
- flush_cnt increments when flush=1 at the edge, and stops at 2^CNT_W−1.
- bubble_cnt increments when the current id_valid=0, and stops at 2^CNT_W−1. Held bubbles are counted every cycle.
- Counters are unsigned. There is no wrap-around; they saturate.

## Timing
- Reset (rst_n=0 at edge): state RUN, id_valid=0, id_squashed=0, id_inst=NOP_INST, id_pc=0, id_pc4=0, flush_cnt=0, bubble_cnt=0.
- Reset overrides flush and stall in the same cycle. Asserting reset mid-stall or mid-squash returns the block to the reset values on the next edge.
- All outputs are registered, with latency 1 cycle from the IF inputs to the ID outputs.
- flush applied in cycle N produces a bubble on the outputs from edge N+1. If flush is held for k cycles, k consecutive bubble cycles result.
- When flush and stall are high together, the slot is squashed and is not held. This prevents the wrong-path instruction from surviving a stall.
- When stall is released, the slot loads the IF inputs at that edge with no extra bubble.
- No combinational path runs from the inputs to the outputs.

## Test plan
- Reset: drive rst_n=0 with flush=1 and stall=1 for 2 edges. All outputs must equal their reset values, with id_inst=0x00000013 and both counters 0.
- Normal flow: load 3 consecutive instructions (pc 0x0, 0x4, 0x8; inst 0x00500093…) with flush=0 and stall=0. Each must appear one cycle later with id_valid=1, and bubble_cnt must stay unchanged after the first load.
- Flush: while pc=0x10 is presented, assert flush for 1 cycle. The next cycle shows id_valid=0, id_squashed=1, id_inst=0x13 and flush_cnt=1. The following cycle loads pc=0x14 normally.
- Stall: assert stall for 3 cycles after pc=0x20 is loaded. id_pc must stay 0x20 for 3 cycles. On release, the IF inputs present at the release edge are loaded and flush_cnt is unchanged.
- Flush during stall: assert flush and stall together. The result is a bubble with state SQUASH. Then hold stall=1 for 2 cycles: the bubble is held, id_squashed stays 1, and bubble_cnt increases by 3.
- Saturation (CNT_W=4): hold flush for 20 cycles. flush_cnt and bubble_cnt must stop at 15 and not wrap to 0.
